// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM sequencing shared ALU, memory port and register file
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;
  state_t state_q, state_d;
  logic pcwrite, branch, mw, irw, rw, done, ill;
  // Next-state selection; any unexpected encoding falls back to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE:  state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                         (op == OP_RTYPE) ? RTYPEEX :
                         (op == OP_BEQ)   ? BEQEX   :
                         (op == OP_ADDI)  ? ADDIEX  :
                         (op == OP_J)     ? JEX     : FETCH;
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  // State register; reset drops the FSM straight back to FETCH, abandoning any in-flight write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end
  // Moore output decode; only FETCH/MEMWR look at mem_ready and DECODE at op for the illegal pulse
  always_comb begin
    {pcwrite, branch, mw, irw, rw, done, ill} = '0;
    {iord, memtoreg, regdst, alusrca} = '0;
    alusrcb = 2'b00;
    pcsrc   = 2'b00;
    aluop   = 2'b00;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irw     = mem_ready;
        pcwrite = mem_ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        ill     = !(op == OP_LW || op == OP_SW || op == OP_RTYPE ||
                    op == OP_BEQ || op == OP_ADDI || op == OP_J);
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        rw       = 1'b1;
        done     = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        mw   = 1'b1;
        done = mem_ready;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst = 1'b1;
        rw     = 1'b1;
        done   = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        done    = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: begin
        rw   = 1'b1;
        done = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end
  // Write enables and pulses are held low for as long as reset is asserted
  assign pcen       = reset_n & (pcwrite | (branch & zero));
  assign memwrite   = reset_n & mw;
  assign irwrite    = reset_n & irw;
  assign regwrite   = reset_n & rw;
  assign instr_done = reset_n & done;
  assign illegal_op = reset_n & ill;
  assign state      = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed scoreboard bench for the multicycle control FSM
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset_n, zero, mem_ready;
  logic [5:0] op;
  logic pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic instr_done, illegal_op;
  logic [3:0] state;
  logic [19:0] sb[$];
  int checks = 0;
  int errors = 0;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTEX = 4'd6, S_RTWB = 4'd7, S_BEQ = 4'd8,
    S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_J = 4'd11;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Expected output word for a given state, built from the control table of the design
  // Layout: state, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
  //         alusrcb, pcsrc, aluop, instr_done, illegal_op
  function automatic logic [19:0] exp_out(input logic [3:0] s, input logic mr, input logic z,
                                          input logic rn, input logic [5:0] o);
    logic pe, mw, ir, rw, io, mt, rd, sa, dn, il;
    logic [1:0] sb2, ps, ao;
    {pe, mw, ir, rw, io, mt, rd, sa, dn, il} = '0;
    {sb2, ps, ao} = '0;
    case (s)
      S_FETCH:  begin sb2 = 2'b01; ir = mr; pe = mr; end
      S_DECODE: begin sb2 = 2'b11;
                  il = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010}); end
      S_MEMADR: begin sa = 1; sb2 = 2'b10; end
      S_MEMRD:  io = 1;
      S_MEMWB:  begin mt = 1; rw = 1; dn = 1; end
      S_MEMWR:  begin io = 1; mw = 1; dn = mr; end
      S_RTEX:   begin sa = 1; ao = 2'b10; end
      S_RTWB:   begin rd = 1; rw = 1; dn = 1; end
      S_BEQ:    begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; dn = 1; end
      S_ADDIEX: begin sa = 1; sb2 = 2'b10; end
      S_ADDIWB: begin rw = 1; dn = 1; end
      S_J:      begin ps = 2'b10; pe = 1; dn = 1; end
      default: ;
    endcase
    if (!rn) {pe, mw, ir, rw, dn, il} = '0;
    return {s, pe, mw, ir, rw, io, mt, rd, sa, sb2, ps, ao, dn, il};
  endfunction

  // Push expectation for the current inputs, then pop and compare against the DUT
  task automatic check_now(input string tag, input logic [3:0] s);
    logic [19:0] got, e;
    sb.push_back(exp_out(s, mem_ready, zero, reset_n, op));
    got = {state, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
           alusrcb, pcsrc, aluop, instr_done, illegal_op};
    e = sb.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, e);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] s, input logic mr, input logic z,
                      input logic [5:0] o);
    @(negedge clk);
    mem_ready = mr;
    zero = z;
    op = o;
    #1;
    check_now(tag, s);
  endtask

  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'b100011;
    // T1 reset
    step("t1_rst0", S_FETCH, 1, 0, 6'b100011);
    step("t1_rst1", S_FETCH, 1, 0, 6'b100011);
    checks++;
    assert (irwrite === 1'b0 && pcen === 1'b0) else begin
      errors++;
      $error("FAIL t1_we: observed %b%b expected 00", irwrite, pcen);
    end
    reset_n = 1'b1;
    #1 check_now("t1_rel", S_FETCH);
    // T2 LW
    step("t2_dec", S_DECODE, 1, 0, 6'b100011);
    step("t2_adr", S_MEMADR, 1, 0, 6'b100011);
    step("t2_rd", S_MEMRD, 1, 0, 6'b100011);
    step("t2_wb", S_MEMWB, 1, 0, 6'b100011);
    step("t2_fetch", S_FETCH, 1, 0, 6'b101011);
    checks++;
    assert (instr_done === 1'b0) else begin
      errors++;
      $error("FAIL t2_pulse: observed %b expected 0", instr_done);
    end
    // T3 SW with 3 wait cycles in MEMWR
    step("t3_dec", S_DECODE, 1, 0, 6'b101011);
    step("t3_adr", S_MEMADR, 1, 0, 6'b101011);
    step("t3_wr0", S_MEMWR, 0, 0, 6'b101011);
    step("t3_wr1", S_MEMWR, 0, 0, 6'b101011);
    step("t3_wr2", S_MEMWR, 0, 0, 6'b101011);
    step("t3_wr3", S_MEMWR, 1, 0, 6'b101011);
    step("t3_fetch", S_FETCH, 1, 0, 6'b000100);
    // T4 BEQ taken then not taken
    step("t4_dec", S_DECODE, 1, 1, 6'b000100);
    step("t4_tk", S_BEQ, 1, 1, 6'b000100);
    checks++;
    assert (pcen === 1'b1 && pcsrc === 2'b01) else begin
      errors++;
      $error("FAIL t4_taken: observed %b/%b expected 1/01", pcen, pcsrc);
    end
    step("t4_fetch", S_FETCH, 1, 0, 6'b000100);
    step("t4_dec2", S_DECODE, 1, 0, 6'b000100);
    step("t4_nt", S_BEQ, 1, 0, 6'b000100);
    // FETCH stall then J
    step("fs_0", S_FETCH, 0, 0, 6'b000010);
    step("fs_1", S_FETCH, 0, 0, 6'b000010);
    step("fs_2", S_FETCH, 1, 0, 6'b000010);
    step("j_dec", S_DECODE, 1, 0, 6'b000010);
    step("j_ex", S_J, 1, 0, 6'b000010);
    // ADDI
    step("ai_f", S_FETCH, 1, 0, 6'b001000);
    step("ai_dec", S_DECODE, 1, 0, 6'b001000);
    step("ai_ex", S_ADDIEX, 1, 0, 6'b001000);
    step("ai_wb", S_ADDIWB, 1, 0, 6'b001000);
    // T5 illegal opcode
    step("t5_f", S_FETCH, 1, 0, 6'b111111);
    step("t5_dec", S_DECODE, 1, 0, 6'b111111);
    step("t5_f2", S_FETCH, 0, 0, 6'b111111);
    // Full R-type
    step("rt_f", S_FETCH, 1, 0, 6'b000000);
    step("rt_dec", S_DECODE, 1, 0, 6'b000000);
    step("rt_ex", S_RTEX, 1, 0, 6'b000000);
    step("rt_wb", S_RTWB, 1, 0, 6'b000000);
    // T6 reset dropped in RTYPEEX
    step("t6_f", S_FETCH, 1, 0, 6'b000000);
    step("t6_dec", S_DECODE, 1, 0, 6'b000000);
    step("t6_ex", S_RTEX, 1, 0, 6'b000000);
    #1 reset_n = 1'b0;
    #1 check_now("t6_async", S_FETCH);
    step("t6_hold", S_FETCH, 1, 0, 6'b000000);
    reset_n = 1'b1;
    #1 check_now("t6_rel", S_FETCH);
    step("t6_dec2", S_DECODE, 1, 0, 6'b000000);
    step("t6_ex2", S_RTEX, 1, 0, 6'b000000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
